// File: rtl/hamming_pkg.sv
// Shared definitions for the pipelined SECDED Hamming codec.
//   - par_w(data_w) : number of Hamming parity bits for a data width
//   - is_pow2(pos)  : true when a codeword position holds a parity bit
//   - data_pos(i)   : codeword index of data bit i
//   - dec_res_t     : decoder result, sized for the widest legal data word
package hamming_pkg;

   localparam int MAX_DATA_W = 57;
   localparam int MAX_PAR_W  = 6;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] data;
      logic [MAX_PAR_W-1:0]  syndrome;
      logic                  single;
      logic                  double;
   } dec_res_t;

   // Smallest P with 2^P >= data_w + P + 1. Scanning downwards leaves the
   // smallest qualifying P in res.
   function automatic int par_w(input int data_w);
      int res;
      res = 0;
      for (int p = MAX_PAR_W; p >= 1; p--) begin
         if ((1 << p) >= data_w + p + 1) res = p;
      end
      return res;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bits occupy the non-power-of-2 positions from 1 upwards, d0 lowest.
   function automatic int data_pos(input int i);
      int res;
      int n;
      res = 0;
      n   = 0;
      for (int k = 1; k < (1 << (MAX_PAR_W + 1)); k++) begin
         if (!is_pow2(k)) begin
            if (n == i) res = k;
            n++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hamming_secded_pipe_if.sv
// Stream and status bundle of hamming_secded_pipe.
//   slave  : codec side (consumes input stream, produces results/counters)
//   master : environment side
// Handshake: a word moves on a rising clock edge exactly when valid && ready
// are both high on that side; a producer holds valid and its payload stable
// until the transfer, and ready never depends on valid.
interface hamming_secded_pipe_if import hamming_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   localparam int PAR_W = par_w(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;

   // input stream
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CW_W-1:0]   inj_mask;
   logic              correct_en;
   // output stream
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CW_W-1:0]   out_codeword;
   logic              err_single;
   logic              err_double;
   logic [PAR_W-1:0]  err_syndrome;
   // status counters
   logic              clr_counts;
   logic [CNT_W-1:0]  cnt_single;
   logic [CNT_W-1:0]  cnt_double;

   modport slave (
      input  in_valid, in_data, inj_mask, correct_en, out_ready, clr_counts,
      output in_ready, out_valid, out_data, out_codeword, err_single,
             err_double, err_syndrome, cnt_single, cnt_double
   );

   modport master (
      output in_valid, in_data, inj_mask, correct_en, out_ready, clr_counts,
      input  in_ready, out_valid, out_data, out_codeword, err_single,
             err_double, err_syndrome, cnt_single, cnt_double
   );

endinterface

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: syndrome, overall-parity check, optional
// single-bit correction and data extraction.
//   cw         : received codeword (bit 0 = overall parity)
//   correct_en : 1 = flip the bit named by a valid single-error syndrome
//   res        : data (zero-extended), syndrome, single/double flags
module hamming_secded_dec import hamming_pkg::*; #(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W+par_w(DATA_W):0] cw,
   input  logic                          correct_en,
   output dec_res_t                      res
);
   localparam int PAR_W = par_w(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;
   localparam int IDX_W = $clog2(CW_W);

   logic [PAR_W-1:0] syn;
   logic             pmis;
   logic             in_range;
   logic [CW_W-1:0]  fixed;

   always_comb begin
      syn = '0;
      for (int k = 1; k < CW_W; k++) begin
         if (cw[k]) syn = syn ^ PAR_W'(k);
      end
      pmis     = ^cw;
      // Only non-full codes can produce a syndrome past the last position.
      in_range = (int'(syn) <= CW_W - 1);

      res          = '0;
      res.syndrome = MAX_PAR_W'(syn);
      fixed        = cw;

      if (syn != '0 && !in_range) begin
         res.double = 1'b1;
      end else if (syn != '0 && pmis) begin
         res.single = 1'b1;
         for (int k = 1; k < CW_W; k++) begin
            if (correct_en && int'(syn) == k) fixed[k] = ~fixed[k];
         end
      end else if (syn == '0 && pmis) begin
         // Overall parity bit itself flipped; data positions are intact.
         res.single = 1'b1;
      end else if (syn != '0) begin
         res.double = 1'b1;
      end

      for (int i = 0; i < DATA_W; i++) begin
         res.data[i] = fixed[IDX_W'(data_pos(i))];
      end
   end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined SECDED Hamming codec with error injection.
//   reloj, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus (slave)  : input stream in_valid/in_ready/in_data/inj_mask/correct_en,
//                  output stream out_valid/out_ready/out_data/out_codeword/
//                  err_single/err_double/err_syndrome, and the saturating
//                  counters cnt_single/cnt_double with clr_counts.
// Stage 1 registers enc(in_data) ^ inj_mask; stage 2 registers the decoded
// result, giving two cycles from accept to out_valid.
module hamming_secded_pipe import hamming_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input logic                  reloj,
   input logic                  rst_n,
   hamming_secded_pipe_if.slave bus
);
   localparam int PAR_W = par_w(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;
   localparam int IDX_W = $clog2(CW_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ---------------- encoder ----------------
   logic [CW_W-1:0] placed;
   logic [CW_W-1:0] enc_cw;
   logic            par_acc;

   always_comb begin
      placed = '0;
      for (int i = 0; i < DATA_W; i++) begin
         placed[IDX_W'(data_pos(i))] = bus.in_data[i];
      end
   end

   // Parity bit 2^p covers every position whose index has bit p set.
   // placed is zero at power-of-2 positions, so those add nothing.
   always_comb begin
      enc_cw  = placed;
      par_acc = 1'b0;
      for (int p = 0; p < PAR_W; p++) begin
         par_acc = 1'b0;
         for (int k = 1; k < CW_W; k++) begin
            if (((k >> p) & 1) != 0) par_acc = par_acc ^ placed[k];
         end
         enc_cw[IDX_W'(1 << p)] = par_acc;
      end
      enc_cw[0] = ^enc_cw[CW_W-1:1];
   end

   // ---------------- pipeline control ----------------
   logic            s1_valid;
   logic [CW_W-1:0] s1_cw;
   logic            s1_cen;

   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic [CW_W-1:0]   out_cw_r;
   logic              err_single_r;
   logic              err_double_r;
   logic [PAR_W-1:0]  err_syn_r;
   logic [CNT_W-1:0]  cnt_single_r;
   logic [CNT_W-1:0]  cnt_double_r;

   logic s2_advance;
   logic in_ready_i;
   logic out_xfer;

   assign s2_advance = !out_valid_r || bus.out_ready;
   assign in_ready_i = !s1_valid || s2_advance;
   assign out_xfer   = out_valid_r && bus.out_ready;

   // ---------------- stage 1 ----------------
   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_cen   <= 1'b0;
      end else if (in_ready_i) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_cw  <= enc_cw ^ bus.inj_mask;
            s1_cen <= bus.correct_en;
         end
      end
   end

   // ---------------- stage 2 ----------------
   dec_res_t dec;
   logic     unused_dec_bits;

   hamming_secded_dec #(.DATA_W(DATA_W)) u_dec (
      .cw         (s1_cw),
      .correct_en (s1_cen),
      .res        (dec)
   );

   // The result struct is sized for the widest code; upper bits stay zero.
   assign unused_dec_bits = ^{dec.data >> DATA_W, dec.syndrome >> PAR_W};

   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_cw_r     <= '0;
         err_single_r <= 1'b0;
         err_double_r <= 1'b0;
         err_syn_r    <= '0;
      end else if (s2_advance) begin
         out_valid_r <= s1_valid;
         if (s1_valid) begin
            out_data_r   <= dec.data[DATA_W-1:0];
            out_cw_r     <= s1_cw;
            err_single_r <= dec.single;
            err_double_r <= dec.double;
            err_syn_r    <= dec.syndrome[PAR_W-1:0];
         end
      end
   end

   // ---------------- counters ----------------
   always_ff @(posedge reloj or negedge rst_n) begin
      if (!rst_n) begin
         cnt_single_r <= '0;
         cnt_double_r <= '0;
      end else if (bus.clr_counts) begin
         cnt_single_r <= '0;
         cnt_double_r <= '0;
      end else if (out_xfer) begin
         if (err_single_r && cnt_single_r != CNT_MAX) cnt_single_r <= cnt_single_r + 1'b1;
         if (err_double_r && cnt_double_r != CNT_MAX) cnt_double_r <= cnt_double_r + 1'b1;
      end
   end

   // ---------------- outputs ----------------
   assign bus.in_ready     = in_ready_i;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_data     = out_data_r;
   assign bus.out_codeword = out_cw_r;
   assign bus.err_single   = err_single_r;
   assign bus.err_double   = err_double_r;
   assign bus.err_syndrome = err_syn_r;
   assign bus.cnt_single   = cnt_single_r;
   assign bus.cnt_double   = cnt_double_r;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe with DATA_W=4, CNT_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hamming_secded_pipe;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] exp_q[$];

   logic [7:0] cw_tab [8] = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69};
   logic       bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   hamming_secded_pipe_if #(.DATA_W(4), .CNT_W(4)) bus ();

   hamming_secded_pipe #(.DATA_W(4), .CNT_W(4)) dut (
      .reloj (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_vec(input string tag, input logic [3:0] d, input logic [7:0] m,
                          input logic cen, input logic [3:0] exp_d, input logic [7:0] exp_cw,
                          input logic exp_s, input logic exp_dbl, input logic [2:0] exp_syn,
                          input logic [3:0] exp_cs, input logic [3:0] exp_cd);
      @(negedge clk);
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = d;
      bus.inj_mask   = m;
      bus.correct_en = cen;
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_early_ov"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_ov"},  32'(bus.out_valid),    32'd1);
      check({tag, "_cw"},  32'(bus.out_codeword), 32'(exp_cw));
      check({tag, "_dat"}, 32'(bus.out_data),     32'(exp_d));
      check({tag, "_es"},  32'(bus.err_single),   32'(exp_s));
      check({tag, "_ed"},  32'(bus.err_double),   32'(exp_dbl));
      check({tag, "_syn"}, 32'(bus.err_syndrome), 32'(exp_syn));
      @(negedge clk);
      check({tag, "_cs"},   32'(bus.cnt_single), 32'(exp_cs));
      check({tag, "_cd"},   32'(bus.cnt_double), 32'(exp_cd));
      check({tag, "_done"}, 32'(bus.out_valid),  32'd0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.clr_counts = 1'b1;
      @(negedge clk);
      bus.clr_counts = 1'b0;
      check("clr_cs", 32'(bus.cnt_single), 32'd0);
      check("clr_cd", 32'(bus.cnt_double), 32'd0);
   endtask

   task automatic run_backpressure();
      int          sent = 0;
      int          rcvd = 0;
      int          cyc  = 0;
      logic        held_valid = 1'b0;
      logic [11:0] held = '0;
      logic        saw_block = 1'b0;
      bus.inj_mask   = 8'h00;
      bus.correct_en = 1'b1;
      while (rcvd < 8 && cyc < 200) begin
         @(negedge clk);
         if (held_valid) begin
            check("bp_hold_ov",  32'(bus.out_valid), 32'd1);
            check("bp_hold_val", 32'({bus.out_codeword, bus.out_data}), 32'(held));
         end
         bus.out_ready = bp_pat[cyc % 4];
         #1;
         if (sent < 8) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(sent);
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (!bus.in_ready) saw_block = 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({cw_tab[sent], 4'(sent)});
            sent++;
         end
         held_valid = 1'b0;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               check("bp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  check("bp_order", 32'({bus.out_codeword, bus.out_data}), 32'(exp_q.pop_front()));
                  check("bp_flags", 32'({bus.err_single, bus.err_double}), 32'd0);
               end
               rcvd++;
            end else begin
               held_valid = 1'b1;
               held       = {bus.out_codeword, bus.out_data};
            end
         end
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_rcvd",    32'(rcvd), 32'd8);
      check("bp_sent",    32'(sent), 32'd8);
      check("bp_blocked", 32'(saw_block), 32'd1);
      check("bp_q_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_saturation();
      bus.out_ready  = 1'b1;
      bus.inj_mask   = 8'h20;
      bus.correct_en = 1'b1;
      bus.in_data    = 4'hB;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         check("sat_in_ready", 32'(bus.in_ready), 32'd1);
         if (k >= 2) check("sat_tput_ov", 32'(bus.out_valid), 32'd1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("sat_cs", 32'(bus.cnt_single), 32'd15);
      check("sat_cd", 32'(bus.cnt_double), 32'd0);
   endtask

   task automatic run_clear_vs_inc();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hB;
      bus.inj_mask = 8'h20;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("cvi_ov", 32'(bus.out_valid), 32'd1);
      check("cvi_es", 32'(bus.err_single), 32'd1);
      bus.clr_counts = 1'b1;
      @(negedge clk);
      bus.clr_counts = 1'b0;
      check("cvi_cs", 32'(bus.cnt_single), 32'd0);
   endtask

   task automatic run_reset_midstream();
      @(negedge clk);
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = 4'h3;
      bus.inj_mask   = 8'h20;
      bus.correct_en = 1'b1;
      @(negedge clk);
      bus.in_data = 4'h5;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("rst_pre_ov", 32'(bus.out_valid), 32'd1);
      check("rst_pre_cs", 32'(bus.cnt_single), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_ov",  32'(bus.out_valid),    32'd0);
      check("rst_cs",  32'(bus.cnt_single),   32'd0);
      check("rst_cd",  32'(bus.cnt_double),   32'd0);
      check("rst_dat", 32'(bus.out_data),     32'd0);
      check("rst_cw",  32'(bus.out_codeword), 32'd0);
      check("rst_es",  32'(bus.err_single),   32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("rst_rel_in_ready", 32'(bus.in_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check("rst_no_stale", 32'(bus.out_valid), 32'd0);
         @(negedge clk);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.inj_mask   = '0;
      bus.correct_en = 1'b1;
      bus.out_ready  = 1'b1;
      bus.clr_counts = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready),     32'd1);
      check("reset_ov",       32'(bus.out_valid),    32'd0);
      check("reset_dat",      32'(bus.out_data),     32'd0);
      check("reset_cw",       32'(bus.out_codeword), 32'd0);
      check("reset_flags",    32'({bus.err_single, bus.err_double, bus.err_syndrome}), 32'd0);
      check("reset_cnts",     32'({bus.cnt_single, bus.cnt_double}), 32'd0);

      //       tag        data   mask   cen   data  cw     s     d     syn   cs     cd
      run_vec("clean_b",  4'hB, 8'h00, 1'b1, 4'hB, 8'hAA, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
      run_vec("sgl_b",    4'hB, 8'h20, 1'b1, 4'hB, 8'h8A, 1'b1, 1'b0, 3'd5, 4'd1, 4'd0);
      run_vec("sgl_nocor",4'hB, 8'h20, 1'b0, 4'h9, 8'h8A, 1'b1, 1'b0, 3'd5, 4'd2, 4'd0);
      run_vec("par0_b",   4'hB, 8'h01, 1'b1, 4'hB, 8'hAB, 1'b1, 1'b0, 3'd0, 4'd3, 4'd0);
      run_vec("dbl_b",    4'hB, 8'h0C, 1'b1, 4'hA, 8'hA6, 1'b0, 1'b1, 3'd1, 4'd3, 4'd1);
      run_vec("clean_5",  4'h5, 8'h00, 1'b1, 4'h5, 8'h5A, 1'b0, 1'b0, 3'd0, 4'd3, 4'd1);
      run_vec("sgl_5_d3", 4'h5, 8'h80, 1'b1, 4'h5, 8'hDA, 1'b1, 1'b0, 3'd7, 4'd4, 4'd1);
      run_vec("clean_f",  4'hF, 8'h00, 1'b1, 4'hF, 8'hFF, 1'b0, 1'b0, 3'd0, 4'd4, 4'd1);
      run_vec("sgl_f_p4", 4'hF, 8'h10, 1'b1, 4'hF, 8'hEF, 1'b1, 1'b0, 3'd4, 4'd5, 4'd1);
      run_vec("clean_0",  4'h0, 8'h00, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd5, 4'd1);

      run_backpressure();
      pulse_clear();
      run_saturation();
      run_clear_vs_inc();

      run_vec("pre_rst",  4'hB, 8'h20, 1'b1, 4'hB, 8'h8A, 1'b1, 1'b0, 3'd5, 4'd1, 4'd0);
      run_reset_midstream();
      run_vec("post_rst", 4'h5, 8'h00, 1'b1, 4'h5, 8'h5A, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
- Parametrised, pipelined SECDED Hamming codec: encodes DATA_W-bit words, applies an optional error-injection mask, then decodes, corrects and flags each word.
- Valid/ready streaming on both sides; 2-cycle latency.
- Saturating single- and double-error counters for board-level status LEDs and displays.
- Successor to the fixed 4-bit combinational Hamming(7,4)+parity demo; used by the FPGA self-test and display designs.

Parameters:
- DATA_W, 4, data width; legal range 4..57.
- CNT_W, 8, width of each error counter.
- Derived localparam PAR_W: smallest P with 2^P >= DATA_W+P+1 (DATA_W=4 -> 3).
- Derived localparam CW_W: DATA_W+PAR_W+1 (DATA_W=4 -> 8).

Ports:
- reloj  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage 1 can accept.
- in_data  in  DATA_W  data word.
- inj_mask  in  CW_W  XOR error mask applied to the codeword; sampled with in_data.
- correct_en  in  1  1 = correct single errors; 0 = detect only.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  corrected data (raw received data on double error or when correct_en=0).
- out_codeword  out  CW_W  received codeword, after injection and before correction.
- err_single  out  1  single error detected.
- err_double  out  1  uncorrectable error detected.
- err_syndrome  out  PAR_W  Hamming syndrome.
- clr_counts  in  1  synchronous counter clear.
- cnt_single  out  CNT_W  saturating count of accepted single-error words.
- cnt_double  out  CNT_W  saturating count of accepted double-error words.

Behaviour:
- Codeword layout:
  - bit 0 = overall parity (XOR of bits 1..CW_W-1).
  - Bits 1..CW_W-1 are Hamming positions; parity bits sit at power-of-2 positions.
  - Data bits fill the remaining positions in ascending order, d0 lowest.
- Stage 1 (encode):
  - On in_valid && in_ready, register codeword = enc(in_data) ^ inj_mask.
  - Also register correct_en with the word.
- Stage 2 (decode):
  - syndrome = XOR of indices of set positions.
  - pmis = XOR of all CW_W bits.
  - syn!=0 && pmis=1 && syn<=CW_W-1: single; flip position syn if correct_en.
  - syn==0 && pmis=1: single (parity bit 0 error); data unaffected.
  - syn!=0 && pmis=0: double; no correction.
  - syn>CW_W-1 (possible only for non-full codes): double.
  - syn==0 && pmis=0: clean.
- All stage-2 outputs are registered. Latency is exactly 2 cycles from input accept to out_valid when there is no backpressure.
- Handshake:
  - Each stage advances when its downstream slot is empty or being drained.
  - in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
  - Words are never dropped or duplicated.
  - Output fields hold stable while out_valid && !out_ready.
  - Full throughput: 1 word/cycle while out_ready=1.
- Counters:
  - Increment on an output transfer (out_valid && out_ready) flagged single or double.
  - Saturate at 2^CNT_W-1.
  - clr_counts wins over a same-cycle increment.
- Reset (including mid-stream):
  - out_valid=0, internal valids=0, all data/flag outputs=0, counters=0.
  - in_ready=1 on the first cycle after rst_n deasserts.
  - In-flight words are discarded.

Decomposition:
- Package hamming_pkg:
  - functions par_w(data_w), is_pow2(pos), data_pos(i) giving the codeword index of data bit i.
  - struct dec_res_t {data, syndrome, single, double}.
- Sub-module hamming_secded_dec: purely combinational syndrome/correct/extract block, instantiated in stage 2.
- Encoder logic stays inline.

Test Plan:
- Clean word: DATA_W=4, in_data=4'hB, inj_mask=0 -> 2 cycles later out_codeword=8'hAA, out_data=4'hB, err_single=0, err_double=0, err_syndrome=0.
- Single data-bit error: in_data=4'hB, inj_mask=8'h20 -> out_codeword=8'h8A, err_syndrome=5, err_single=1, out_data=4'hB, cnt_single=1. Same stimulus with correct_en=0 -> out_data=4'h9.
- Overall-parity error: inj_mask=8'h01 -> err_syndrome=0, err_single=1, out_data=4'hB.
- Double error: in_data=4'hB, inj_mask=8'h0C -> err_syndrome=1, err_double=1, err_single=0, out_data=4'hA, cnt_double=1.
- Backpressure: stream 4'h0..4'h7 with out_ready toggling 1,0,0,1 -> in_ready drops when both stages are full; outputs arrive in order, stable while stalled, none lost.
- Saturation, clear and reset:
  - CNT_W=4: 20 single-error words -> cnt_single=15.
  - clr_counts concurrent with an error transfer -> cnt_single=0.
  - rst_n low with 2 words in flight -> out_valid=0 and counters=0 immediately; no stale outputs after release.
